mem_arbiter: RTL and testbench

Two-port memory arbiter that shares the single VeriRISC program/data memory between the CPU control path and a program-loader/debug port. Each requester presents one-word read or write commands through a req/gnt handshake. The block serialises the commands with round-robin priority, drives the memory strobes, and returns completion and read data. It sits between the CPU datapath (memory side of `mem_rd`/`mem_wr`), the loader, and the 32×8 memory.

---
 rtl/mem_arbiter.sv | 112 +++++++++++
 tb/tb_mem_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port round-robin arbiter for the shared program/data memory
module mem_arbiter #(
  parameter int AWIDTH = 5,
  parameter int DWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic              cpu_req,
  input  logic              cpu_wr,
  input  logic [AWIDTH-1:0] cpu_addr,
  input  logic [DWIDTH-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_done,
  input  logic              ldr_req,
  input  logic              ldr_wr,
  input  logic [AWIDTH-1:0] ldr_addr,
  input  logic [DWIDTH-1:0] ldr_wdata,
  output logic              ldr_gnt,
  output logic              ldr_done,
  output logic [DWIDTH-1:0] rdata,
  output logic              busy,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0] mem_wdata,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic [DWIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACCESS   = 2'd1,
    COMPLETE = 2'd2
  } state_t;

  state_t            state;
  logic              last;      // 1 = loader won the most recent arbitration
  logic              owner;     // 1 = loader owns the in-flight command
  logic              cmd_wr;
  logic [AWIDTH-1:0] cmd_addr;
  logic [DWIDTH-1:0] cmd_wdata;

  logic              arb_en;
  logic              accept;
  logic              sel_wr;
  logic [AWIDTH-1:0] sel_addr;
  logic [DWIDTH-1:0] sel_wdata;

  // Grants are only offered outside the strobe cycle; on a tie the port that
  // did not win last time goes first.
  assign arb_en  = (state != ACCESS);
  assign cpu_gnt = arb_en & cpu_req & (~ldr_req | last);
  assign ldr_gnt = arb_en & ldr_req & (~cpu_req | ~last);
  assign accept  = cpu_gnt | ldr_gnt;

  assign sel_wr    = ldr_gnt ? ldr_wr    : cpu_wr;
  assign sel_addr  = ldr_gnt ? ldr_addr  : cpu_addr;
  assign sel_wdata = ldr_gnt ? ldr_wdata : cpu_wdata;

  // Address and write data come straight from the latched command.
  assign mem_addr  = cmd_addr;
  assign mem_wdata = cmd_wdata;

  // Control FSM: latch the winner, strobe for one cycle, capture data, pulse done.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state     <= IDLE;
      last      <= 1'b1;
      owner     <= 1'b0;
      cmd_wr    <= 1'b0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
      cpu_done  <= 1'b0;
      ldr_done  <= 1'b0;
      rdata     <= '0;
      busy      <= 1'b0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
    end else begin
      cpu_done <= 1'b0;
      ldr_done <= 1'b0;
      mem_rd   <= 1'b0;
      mem_wr   <= 1'b0;

      if (state == COMPLETE) begin
        cpu_done <= ~owner;
        ldr_done <= owner;
        if (!cmd_wr) begin
          rdata <= mem_rdata;
        end
      end

      if (accept) begin
        owner     <= ldr_gnt;
        last      <= ldr_gnt;
        cmd_wr    <= sel_wr;
        cmd_addr  <= sel_addr;
        cmd_wdata <= sel_wdata;
        mem_rd    <= ~sel_wr;
        mem_wr    <= sel_wr;
        busy      <= 1'b1;
        state     <= ACCESS;
      end else if (state == ACCESS) begin
        busy  <= 1'b1;
        state <= COMPLETE;
      end else begin
        busy  <= 1'b0;
        state <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter
module tb_mem_arbiter;

  logic       clk = 1'b0;
  logic       rst_ = 1'b0;
  logic       cpu_req, cpu_wr, ldr_req, ldr_wr;
  logic [4:0] cpu_addr, ldr_addr, mem_addr;
  logic [7:0] cpu_wdata, ldr_wdata, rdata, mem_wdata, mem_rdata;
  logic       cpu_gnt, cpu_done, ldr_gnt, ldr_done, busy, mem_rd, mem_wr;

  mem_arbiter #(.AWIDTH(5), .DWIDTH(8)) dut (
    .clk(clk), .rst_(rst_),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_done(cpu_done),
    .ldr_req(ldr_req), .ldr_wr(ldr_wr), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .ldr_gnt(ldr_gnt), .ldr_done(ldr_done),
    .rdata(rdata), .busy(busy),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       wr;
    logic [4:0] addr;
    logic [7:0] wdata;
  } cmd_t;

  typedef struct {
    logic       port;
    logic       wr;
    logic [4:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdexp;
    int         gcyc;
  } exp_t;

  cmd_t       cpu_q[$];
  cmd_t       ldr_q[$];
  exp_t       sb[$];
  exp_t       st_q[$];
  logic       grant_port[$];
  int         grant_cyc[$];
  int         done_cyc[$];
  int         strobe_cyc[$];

  logic [7:0] mem [32];
  logic [7:0] shadow [32];
  logic       load_en = 1'b0;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  int         bad_strobe = 0;
  int         bad_gnt = 0;
  int         busy_cnt = 0;
  int         wr_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Memory model: one write per strobe, read data valid the cycle after mem_rd.
  always @(posedge clk) begin
    if (load_en) begin
      for (int i = 0; i < 32; i++) mem[i] <= shadow[i];
    end else begin
      if (mem_wr) mem[mem_addr] <= mem_wdata;
      if (mem_rd) mem_rdata <= mem[mem_addr];
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic grant(input logic port, input logic wr, input logic [4:0] addr, input logic [7:0] wdata);
    exp_t e;
    e.port  = port;
    e.wr    = wr;
    e.addr  = addr;
    e.wdata = wdata;
    e.rdexp = shadow[addr];
    e.gcyc  = cyc;
    if (wr) shadow[addr] = wdata;
    sb.push_back(e);
    st_q.push_back(e);
    grant_port.push_back(port);
    grant_cyc.push_back(cyc);
  endtask

  // CPU driver: present the head command until it is granted.
  initial begin
    cmd_t c;
    cpu_req = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    forever begin
      @(posedge clk); #1;
      if (cpu_q.size() > 0) begin
        c = cpu_q[0];
        cpu_req = 1'b1; cpu_wr = c.wr; cpu_addr = c.addr; cpu_wdata = c.wdata;
      end else begin
        cpu_req = 1'b0;
      end
      @(negedge clk);
      if (cpu_req && cpu_gnt && rst_) void'(cpu_q.pop_front());
    end
  end

  // Loader driver: same protocol as the CPU driver.
  initial begin
    cmd_t c;
    ldr_req = 1'b0; ldr_wr = 1'b0; ldr_addr = '0; ldr_wdata = '0;
    forever begin
      @(posedge clk); #1;
      if (ldr_q.size() > 0) begin
        c = ldr_q[0];
        ldr_req = 1'b1; ldr_wr = c.wr; ldr_addr = c.addr; ldr_wdata = c.wdata;
      end else begin
        ldr_req = 1'b0;
      end
      @(negedge clk);
      if (ldr_req && ldr_gnt && rst_) void'(ldr_q.pop_front());
    end
  end

  // Monitor: record grants, check strobes and dones against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_) begin
        if (mem_rd && mem_wr) bad_strobe++;
        if ((cpu_gnt && ldr_gnt) || (cpu_gnt && !cpu_req) || (ldr_gnt && !ldr_req)) bad_gnt++;
        if ((mem_rd || mem_wr) && (cpu_gnt || ldr_gnt)) bad_gnt++;
        if (!(mem_rd || mem_wr) && (cpu_req || ldr_req) && !(cpu_gnt || ldr_gnt)) bad_gnt++;
        if (busy) busy_cnt++;
        if (mem_wr) wr_cnt++;
        if (cpu_req && cpu_gnt) grant(1'b0, cpu_wr, cpu_addr, cpu_wdata);
        if (ldr_req && ldr_gnt) grant(1'b1, ldr_wr, ldr_addr, ldr_wdata);
        if (mem_rd || mem_wr) begin
          strobe_cyc.push_back(cyc);
          if (st_q.size() == 0) begin
            chk("strobe_unexpected", 32'd1, 32'd0);
          end else begin
            e = st_q.pop_front();
            chk("strobe_wr", {31'd0, mem_wr}, {31'd0, e.wr});
            chk("strobe_addr", {27'd0, mem_addr}, {27'd0, e.addr});
            if (e.wr) chk("strobe_wdata", {24'd0, mem_wdata}, {24'd0, e.wdata});
            chk("strobe_latency", cyc - e.gcyc, 32'd1);
          end
        end
        if (cpu_done || ldr_done) begin
          done_cyc.push_back(cyc);
          if (cpu_done && ldr_done) chk("done_both", 32'd1, 32'd0);
          if (sb.size() == 0) begin
            chk("done_unexpected", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            chk("done_port", {31'd0, ldr_done}, {31'd0, e.port});
            chk("done_latency", cyc - e.gcyc, 32'd3);
            if (!e.wr) chk("rdata", {24'd0, rdata}, {24'd0, e.rdexp});
          end
        end
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while ((cpu_q.size() > 0 || ldr_q.size() > 0 || sb.size() > 0 || busy) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", {31'd0, n < 300}, 32'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_ = 1'b0;
    repeat (2) @(negedge clk);
    rst_ = 1'b1;
    @(negedge clk);
  endtask

  function automatic cmd_t mk(input logic wr, input logic [4:0] addr, input logic [7:0] wdata);
    cmd_t c;
    c.wr = wr; c.addr = addr; c.wdata = wdata;
    return c;
  endfunction

  initial begin
    int g0, d0, s0, b0, w0, t0, n;
    for (int i = 0; i < 32; i++) shadow[i] = 8'(i * 7 + 3);
    shadow[5] = 8'hA7;
    shadow[4] = 8'h11;
    load_en = 1'b1;
    repeat (3) @(negedge clk);
    load_en = 1'b0;

    // Reset state
    chk("reset_gnt", {30'd0, cpu_gnt, ldr_gnt}, 32'd0);
    chk("reset_done", {30'd0, cpu_done, ldr_done}, 32'd0);
    chk("reset_busy_strobes", {29'd0, busy, mem_rd, mem_wr}, 32'd0);
    chk("reset_mem_addr", {27'd0, mem_addr}, 32'd0);
    chk("reset_mem_wdata", {24'd0, mem_wdata}, 32'd0);
    chk("reset_rdata", {24'd0, rdata}, 32'd0);
    rst_ = 1'b1;
    @(negedge clk);

    // CPU read of address 5, granted in the first presented cycle
    g0 = grant_port.size();
    t0 = cyc;
    cpu_q.push_back(mk(1'b0, 5'd5, 8'h00));
    wait_idle();
    chk("t1_grants", grant_port.size() - g0, 32'd1);
    if (grant_cyc.size() > g0) chk("t1_gnt_cycle", grant_cyc[g0] - t0, 32'd1);

    // Loader write 0x3C to address 31, then CPU reads it back
    w0 = wr_cnt;
    ldr_q.push_back(mk(1'b1, 5'd31, 8'h3C));
    wait_idle();
    chk("t2_wr_cycles", wr_cnt - w0, 32'd1);
    chk("t2_mem31", {24'd0, mem[31]}, 32'h3C);
    cpu_q.push_back(mk(1'b0, 5'd31, 8'h00));
    wait_idle();

    // Tie straight out of reset: CPU first, loader in CPU's COMPLETE
    do_reset();
    g0 = grant_port.size();
    d0 = done_cyc.size();
    cpu_q.push_back(mk(1'b0, 5'd7, 8'h00));
    ldr_q.push_back(mk(1'b1, 5'd9, 8'h5E));
    wait_idle();
    chk("t3_grants", grant_port.size() - g0, 32'd2);
    if (grant_port.size() >= g0 + 2) begin
      chk("t3_first", {31'd0, grant_port[g0]}, 32'd0);
      chk("t3_second", {31'd0, grant_port[g0+1]}, 32'd1);
      chk("t3_gnt_gap", grant_cyc[g0+1] - grant_cyc[g0], 32'd2);
    end
    if (done_cyc.size() >= d0 + 2) chk("t3_done_gap", done_cyc[d0+1] - done_cyc[d0], 32'd2);

    // Continuous contention for 8 transactions
    g0 = grant_port.size();
    s0 = strobe_cyc.size();
    b0 = busy_cnt;
    for (int i = 0; i < 4; i++) begin
      cpu_q.push_back(mk(1'b0, 5'(10 + i), 8'h00));
      ldr_q.push_back(mk(1'b1, 5'(10 + i), 8'(8'hC0 + i)));
    end
    wait_idle();
    chk("t4_grants", grant_port.size() - g0, 32'd8);
    if (grant_port.size() >= g0 + 8) begin
      for (int i = 0; i < 8; i++) chk($sformatf("t4_order%0d", i), {31'd0, grant_port[g0+i]}, 32'(i % 2));
    end
    chk("t4_busy_cycles", busy_cnt - b0, 32'd16);
    chk("t4_strobes", strobe_cyc.size() - s0, 32'd8);
    if (strobe_cyc.size() >= s0 + 8) begin
      for (int i = 1; i < 8; i++) chk($sformatf("t4_strobe_gap%0d", i), strobe_cyc[s0+i] - strobe_cyc[s0+i-1], 32'd2);
    end

    // Back-to-back CPU reads of 1,2,3
    g0 = grant_port.size();
    for (int i = 1; i <= 3; i++) cpu_q.push_back(mk(1'b0, 5'(i), 8'h00));
    wait_idle();
    chk("t5_grants", grant_port.size() - g0, 32'd3);
    if (grant_port.size() >= g0 + 3) begin
      chk("t5_gap1", grant_cyc[g0+1] - grant_cyc[g0], 32'd2);
      chk("t5_gap2", grant_cyc[g0+2] - grant_cyc[g0+1], 32'd2);
    end

    // Reset during the ACCESS cycle of a loader write to address 4
    g0 = grant_port.size();
    ldr_q.push_back(mk(1'b1, 5'd4, 8'h5A));
    n = 0;
    while (grant_port.size() == g0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("t6_grant_timeout", {31'd0, n < 50}, 32'd1);
    @(posedge clk); #2;
    chk("t6_pre_wr", {31'd0, mem_wr}, 32'd1);
    rst_ = 1'b0;
    #1;
    chk("t6_strobes_drop", {30'd0, mem_rd, mem_wr}, 32'd0);
    sb.delete();
    st_q.delete();
    shadow[4] = 8'h11;
    repeat (3) @(negedge clk);
    rst_ = 1'b1;
    repeat (4) @(negedge clk);
    chk("t6_mem4", {24'd0, mem[4]}, 32'h11);
    g0 = grant_port.size();
    t0 = cyc;
    cpu_q.push_back(mk(1'b0, 5'd4, 8'h00));
    wait_idle();
    chk("t6_grants", grant_port.size() - g0, 32'd1);
    if (grant_cyc.size() > g0) chk("t6_gnt_cycle", grant_cyc[g0] - t0, 32'd1);

    chk("strobe_overlap", bad_strobe, 32'd0);
    chk("gnt_rules", bad_gnt, 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
